trng_uart_rx: RTL and testbench

- UART receiver for the TRNG serial output stream (8N1, LSB first, idle high), used on the capture/bench side to rebuild bytes from the TRNG transmit line.
- Synchronizes the asynchronous serial line and detects the start bit.
- Samples each bit at mid-bit and presents completed bytes through a one-entry valid/ready holding register.
- Reports framing errors, overruns and (optionally) parity errors.

---
 rtl/trng_uart_rx.sv | 187 ++++++++++++++++++
 tb/tb_trng_uart_rx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/trng_uart_rx.sv
// UART receiver for the TRNG serial stream: 8N1, LSB first, with a one-entry valid/ready holding register.
// Define TRNG_UART_RX_PARITY_EN for 8E1 framing with a parity_err pulse output.
module trng_uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       overrun_clr,
`ifdef TRNG_UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef TRNG_UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [7:0]           shift_q, shift_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 rx_s;
    logic                 cnt_zero;
    logic                 byte_done;
    logic                 frame_hit;
`ifdef TRNG_UART_RX_PARITY_EN
    logic                 par_q, par_d;
    logic                 par_hit;
`endif

    // Flops preset to 1 so reset does not look like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign cnt_zero = (cnt_q == '0);
    assign busy     = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
`ifdef TRNG_UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
`ifdef TRNG_UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        frame_hit = 1'b0;
`ifdef TRNG_UART_RX_PARITY_EN
        par_d     = par_q;
        par_hit   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    cnt_d   = HALF_LOAD;
                    state_d = START;
                end
            end
            START: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!rx_s) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                    cnt_d   = FULL_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d[idx_q] = rx_s;
                    cnt_d          = FULL_LOAD;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef TRNG_UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef TRNG_UART_RX_PARITY_EN
            PARITY: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    par_d   = rx_s;
                    cnt_d   = FULL_LOAD;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx_s) begin
                    // Back to IDLE at mid-stop so a following start bit is not missed.
                    state_d = IDLE;
`ifdef TRNG_UART_RX_PARITY_EN
                    if (^{shift_q, par_q}) par_hit   = 1'b1;
                    else                   byte_done = 1'b1;
`else
                    byte_done = 1'b1;
`endif
                end else begin
                    frame_hit = 1'b1;
                    state_d   = BREAK;
                end
            end
            BREAK: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
`ifdef TRNG_UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= frame_hit;
`ifdef TRNG_UART_RX_PARITY_EN
            parity_err <= par_hit;
`endif
            if (byte_done && (!rx_valid || rx_ready)) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            // Set beats clear when both land in the same cycle.
            if (byte_done && rx_valid && !rx_ready) overrun <= 1'b1;
            else if (overrun_clr)                   overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_trng_uart_rx.sv
// Directed bench for trng_uart_rx at CLKS_PER_BIT=8; parity checks run when TRNG_UART_RX_PARITY_EN is defined.
module tb_trng_uart_rx;

    localparam int CPB  = 8;
    localparam int SYNC = 2;
`ifdef TRNG_UART_RX_PARITY_EN
    localparam int LAT = 1 + SYNC + 76 + CPB;
`else
    localparam int LAT = 1 + SYNC + 76;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       overrun_clr;
    logic       busy;
`ifdef TRNG_UART_RX_PARITY_EN
    logic       parity_err;
`endif

    trng_uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .overrun_clr(overrun_clr),
`ifdef TRNG_UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge.
    int       vld_cyc = 0, rise_cnt = 0, rise_cyc = 0, fe_cnt = 0, pe_cnt = 0, busy_cyc = 0;
    logic [7:0] rise_data = 8'h00;
    logic     vld_prev = 1'b0;
    always @(negedge clk) begin
        if (rx_valid) vld_cyc++;
        if (rx_valid && !vld_prev) begin
            rise_cnt++;
            rise_cyc  = cyc;
            rise_data = rx_data;
        end
        vld_prev = rx_valid;
        if (frame_err) fe_cnt++;
        if (busy) busy_cyc++;
`ifdef TRNG_UART_RX_PARITY_EN
        if (parity_err) pe_cnt++;
`endif
    end

    int vectors = 0, miscompares = 0;
    int start_cyc = 0;
    int r0, v0, f0, p0, b0;
    logic last_par;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        r0 = rise_cnt; v0 = vld_cyc; f0 = fe_cnt; p0 = pe_cnt; b0 = busy_cyc;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; returns at the same phase.
    task automatic send(input logic [7:0] b, input logic stop, input logic par);
        start_cyc = cyc;
        last_par  = par;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef TRNG_UART_RX_PARITY_EN
        drive_bit(par);
`endif
        drive_bit(stop);
    endtask

    function automatic logic epar(input logic [7:0] b);
        return ^b;
    endfunction

    initial begin
        rst_n = 1'b0; rx = 1'b1; rx_ready = 1'b1; overrun_clr = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk); #1;

        // Basic byte and latency
        snap();
        send(8'hA5, 1'b1, epar(8'hA5));
        repeat (4) @(posedge clk); #1;
        chk("a5_rise_cnt", 32'(rise_cnt - r0), 32'd1);
        chk("a5_data", 32'(rise_data), 32'hA5);
        chk("a5_latency", 32'(rise_cyc - start_cyc), 32'(LAT));
        chk("a5_valid_1cyc", 32'(vld_cyc - v0), 32'd1);
        chk("a5_no_frame_err", 32'(fe_cnt - f0), 32'd0);

        // 3-cycle low glitch
        snap();
        rx = 1'b0;
        repeat (3) @(posedge clk); #1;
        rx = 1'b1;
        repeat (12) @(posedge clk); #1;
        chk("glitch_busy_1to4", 32'((busy_cyc - b0) >= 1 && (busy_cyc - b0) <= 4), 32'd1);
        chk("glitch_no_valid", 32'(rise_cnt - r0), 32'd0);
        chk("glitch_no_frame_err", 32'(fe_cnt - f0), 32'd0);
        chk("glitch_idle", 32'(busy), 32'd0);

        // Bad stop bit followed by a long break
        snap();
        send(8'h3C, 1'b0, epar(8'h3C));
        repeat (40) @(posedge clk); #1;
        rx = 1'b1;
        repeat (3 * CPB) @(posedge clk); #1;
        chk("break_one_frame_err", 32'(fe_cnt - f0), 32'd1);
        chk("break_no_valid", 32'(rise_cnt - r0), 32'd0);
        chk("break_idle", 32'(busy), 32'd0);
        snap();
        send(8'h5A, 1'b1, epar(8'h5A));
        repeat (4) @(posedge clk); #1;
        chk("after_break_cnt", 32'(rise_cnt - r0), 32'd1);
        chk("after_break_data", 32'(rise_data), 32'h5A);

        // Overrun with consumer stalled
        rx_ready = 1'b0;
        snap();
        send(8'h11, 1'b1, epar(8'h11));
        send(8'h22, 1'b1, epar(8'h22));
        repeat (4) @(posedge clk); #1;
        chk("ovr_valid", 32'(rx_valid), 32'd1);
        chk("ovr_data_held", 32'(rx_data), 32'h11);
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_one_rise", 32'(rise_cnt - r0), 32'd1);
        overrun_clr = 1'b1; rx_ready = 1'b1;
        @(posedge clk); #1;
        overrun_clr = 1'b0;
        chk("ovr_cleared", 32'(overrun), 32'd0);
        chk("ovr_consumed", 32'(rx_valid), 32'd0);

        // Reset in the middle of bit 4
        snap();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        rx = 1'b0;
        repeat (CPB / 2) @(posedge clk); #1;
        rst_n = 1'b0; rx = 1'b1;
        #2;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rx_data", 32'(rx_data), 32'd0);
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3 * CPB) @(posedge clk); #1;
        chk("abort_no_valid", 32'(rise_cnt - r0), 32'd0);
        chk("abort_no_frame_err", 32'(fe_cnt - f0), 32'd0);
        snap();
        send(8'hFF, 1'b1, epar(8'hFF));
        repeat (4) @(posedge clk); #1;
        chk("ff_cnt", 32'(rise_cnt - r0), 32'd1);
        chk("ff_data", 32'(rise_data), 32'hFF);

`ifdef TRNG_UART_RX_PARITY_EN
        // 0x07 has three ones: even parity bit is 1
        snap();
        send(8'h07, 1'b1, 1'b0);
        repeat (4) @(posedge clk); #1;
        chk("par_bad_pulse", 32'(pe_cnt - p0), 32'd1);
        chk("par_bad_no_valid", 32'(rise_cnt - r0), 32'd0);
        chk("par_bad_no_frame", 32'(fe_cnt - f0), 32'd0);
        snap();
        send(8'h07, 1'b1, 1'b1);
        repeat (4) @(posedge clk); #1;
        chk("par_ok_no_pulse", 32'(pe_cnt - p0), 32'd0);
        chk("par_ok_cnt", 32'(rise_cnt - r0), 32'd1);
        chk("par_ok_data", 32'(rise_data), 32'h07);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
